// File: rtl/regfile_scoreboard.sv
// Register file with issue scoreboard: DEPTH x WIDTH registers, one write port,
// two combinational read ports with write-through bypass, per-register busy bits.
// Latency: reads 0 cycles, writes/marks/count visible 1 cycle later; no backpressure.
// Ports: clock / ctrl_reset (sync, active-high); write port (ctrl_writeEnable,
//   ctrl_writeReg, data_writeReg); read ports A/B (ctrl_readRegX -> data_readRegX,
//   busy_X); issue mark (ctrl_markBusy, ctrl_busyReg); busy_count.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  input  logic              ctrl_markBusy,
  input  logic [ADDR_W-1:0] ctrl_busyReg,
  output logic              busy_A,
  output logic              busy_B,
  output logic [ADDR_W:0]   busy_count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  count_q, count_d;

  // An address is usable if it lies inside the bank and is not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic wr_ok, mk_ok;
  logic rd_ok_a, rd_ok_b, hit_a, hit_b;
  logic set_inc, clr_dec;

  assign wr_ok   = ctrl_writeEnable && addr_ok(ctrl_writeReg);
  assign mk_ok   = ctrl_markBusy && addr_ok(ctrl_busyReg);
  assign rd_ok_a = addr_ok(ctrl_readRegA);
  assign rd_ok_b = addr_ok(ctrl_readRegB);
  assign hit_a   = wr_ok && (ctrl_writeReg == ctrl_readRegA);
  assign hit_b   = wr_ok && (ctrl_writeReg == ctrl_readRegB);

  assign data_readRegA = !rd_ok_a ? '0 : (hit_a ? data_writeReg : regs_q[ctrl_readRegA]);
  assign data_readRegB = !rd_ok_b ? '0 : (hit_b ? data_writeReg : regs_q[ctrl_readRegB]);

  // A same-cycle writeback resolves the hazard since its data is bypassed.
  assign busy_A = rd_ok_a && !hit_a && busy_q[ctrl_readRegA];
  assign busy_B = rd_ok_b && !hit_b && busy_q[ctrl_readRegB];

  // Mark is applied after clear, so a new producer on the written register wins.
  // The counter follows actual bit transitions only.
  always_comb begin
    busy_d  = busy_q;
    set_inc = 1'b0;
    clr_dec = 1'b0;
    if (wr_ok) begin
      busy_d[ctrl_writeReg] = 1'b0;
    end
    if (mk_ok) begin
      busy_d[ctrl_busyReg] = 1'b1;
    end
    set_inc = mk_ok && !busy_q[ctrl_busyReg];
    clr_dec = wr_ok && busy_q[ctrl_writeReg] && !(mk_ok && (ctrl_busyReg == ctrl_writeReg));
    count_d = count_q + (ADDR_W+1)'(set_inc) - (ADDR_W+1)'(clr_dec);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) begin
        regs_q[ctrl_writeReg] <= data_writeReg;
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;

endmodule
